// File: rtl/quadrature_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : quadrature_decoder_if
//  Purpose  : Bundles the control, encoder-pin and result signals of the
//             quadrature decoder so they travel as a single port.
//  Ports    : enable, clear, error_clr  - decoder controls
//             quad_a, quad_b            - raw encoder channels (async to clk)
//             step, dir, count, error   - decoded step stream and status
//  Modports : master - the side driving controls/pins (e.g. a host or bench)
//             slave  - the decoder itself
//  Revision : 1.0 - initial release
// ============================================================================
interface quadrature_decoder_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             clear;
  logic             error_clr;
  logic             quad_a;
  logic             quad_b;
  logic             step;
  logic             dir;
  logic [WIDTH-1:0] count;
  logic             error;

  modport master (
    output enable, clear, error_clr, quad_a, quad_b,
    input  step, dir, count, error
  );

  modport slave (
    input  enable, clear, error_clr, quad_a, quad_b,
    output step, dir, count, error
  );
endinterface
`default_nettype wire

// File: rtl/quadrature_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : quadrature_decoder
//  Purpose  : Synchronizes and deglitches a two-phase quadrature encoder,
//             decodes each Gray-code transition into a one-cycle step pulse
//             plus direction, keeps a wrapping position count and raises a
//             sticky flag on illegal (both-channel) transitions.
//  Ports    : clk    - rising-edge clock
//             reset  - asynchronous, active-low reset
//             bus    - quadrature_decoder_if.slave
//                      (enable, clear, error_clr, quad_a, quad_b in;
//                       step, dir, count, error out)
//  Revision : 1.0 - initial release
// ============================================================================
module quadrature_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  quadrature_decoder_if.slave  bus
);

  localparam int c_fcnt_w   = $clog2(FILTER_LEN + 1);
  localparam int c_init_len = SYNC_STAGES + FILTER_LEN;
  localparam int c_icnt_w   = $clog2(c_init_len + 1);

  localparam logic [c_fcnt_w-1:0] c_fcnt_last = c_fcnt_w'(FILTER_LEN - 1);
  localparam logic [c_icnt_w-1:0] c_icnt_last = c_icnt_w'(c_init_len - 1);

  localparam logic [0:0] c_st_init = 1'b0;
  localparam logic [0:0] c_st_run  = 1'b1;

  // Channel packing used throughout: bit 1 = A, bit 0 = B.
  logic [SYNC_STAGES-1:0][1:0] r_sync;
  logic [1:0]                  w_synced;
  logic [1:0]                  r_filt;
  logic [1:0]                  r_prev;
  logic [c_fcnt_w-1:0]         r_fcnt [2];
  logic [c_icnt_w-1:0]         r_icnt;
  logic [0:0]                  r_state;

  logic                        r_step;
  logic                        r_dir;
  logic [WIDTH-1:0]            r_count;
  logic                        r_error;

  logic [1:0]                  w_delta;
  logic                        w_run;
  logic                        w_legal;
  logic                        w_illegal;
  logic                        w_up;
  logic                        w_step_now;

  // --------------------------------------------------------------------------
  // Input synchronizer chains (both channels shift together)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], {bus.quad_a, bus.quad_b}};
    end
  end

  assign w_synced = r_sync[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Start-up sequencer: INIT covers the time for a reset-time pin level to
  // flush through the synchronizer and filter, so the decoder starts from the
  // real pin state instead of reporting a bogus transition from 00.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_st_init;
      r_icnt  <= '0;
    end else if (r_state == c_st_init) begin
      if (r_icnt == c_icnt_last) begin
        r_state <= c_st_run;
      end else begin
        r_icnt <= r_icnt + 1'b1;
      end
    end
  end

  assign w_run = (r_state == c_st_run);

  // --------------------------------------------------------------------------
  // Deglitch filter: a new synced level is accepted on the edge its run
  // length reaches FILTER_LEN; any return to the filtered level restarts it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_filt <= '0;
      r_prev <= '0;
      for (int ch = 0; ch < 2; ch++) begin
        r_fcnt[ch] <= '0;
      end
    end else if (!w_run) begin
      r_filt <= w_synced;
      r_prev <= w_synced;
      for (int ch = 0; ch < 2; ch++) begin
        r_fcnt[ch] <= '0;
      end
    end else begin
      r_prev <= r_filt;
      for (int ch = 0; ch < 2; ch++) begin
        if (w_synced[ch] == r_filt[ch]) begin
          r_fcnt[ch] <= '0;
        end else if (r_fcnt[ch] == c_fcnt_last) begin
          r_fcnt[ch] <= '0;
          r_filt[ch] <= w_synced[ch];
        end else begin
          r_fcnt[ch] <= r_fcnt[ch] + 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Transition decode. In the up sequence 00->10->11->01->00 the new A level
  // is always the inverse of the previous B level, which gives direction.
  // --------------------------------------------------------------------------
  assign w_delta    = r_filt ^ r_prev;
  assign w_legal    = w_run && ((w_delta == 2'b01) || (w_delta == 2'b10));
  assign w_illegal  = w_run && (w_delta == 2'b11);
  assign w_up       = r_filt[1] ^ r_prev[0];
  assign w_step_now = bus.enable && w_legal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_step  <= 1'b0;
      r_dir   <= 1'b1;
      r_count <= '0;
      r_error <= 1'b0;
    end else begin
      r_step <= w_step_now;

      if (w_step_now) begin
        r_dir <= w_up;
      end

      // Clear beats a simultaneous step; step/dir above are still reported.
      if (bus.clear) begin
        r_count <= '0;
      end else if (w_step_now) begin
        r_count <= w_up ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));
      end

      // A fresh illegal transition beats error_clr on the same edge.
      if (bus.enable && w_illegal) begin
        r_error <= 1'b1;
      end else if (bus.error_clr) begin
        r_error <= 1'b0;
      end
    end
  end

  assign bus.step  = r_step;
  assign bus.dir   = r_dir;
  assign bus.count = r_count;
  assign bus.error = r_error;

endmodule
`default_nettype wire

// File: tb/tb_quadrature_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_quadrature_decoder
//  Purpose  : Directed self-checking bench for quadrature_decoder
//             (WIDTH=4, SYNC_STAGES=2, FILTER_LEN=3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_quadrature_decoder;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  quadrature_decoder_if #(.WIDTH(4)) qif ();

  quadrature_decoder #(
    .WIDTH       (4),
    .SYNC_STAGES (2),
    .FILTER_LEN  (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (qif)
  );

  int n_vectors     = 0;
  int n_miscompares = 0;

  // Up sequence from 00, as {A,B}
  logic [1:0] up_seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Apply a pin level and hold it 8 clocks; report step pulse count and the
  // clock index (1-based, edge after the change = 1) of the first pulse.
  task automatic move(input logic a, input logic b, output int pulses, output int first);
    pulses = 0;
    first  = 0;
    qif.quad_a = a;
    qif.quad_b = b;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (qif.step === 1'b1) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
  endtask

  initial begin
    int p;
    int f;
    int e;
    int exp_cnt;

    // ---------------- 1: reset with A=B=1, then INIT ----------------
    reset         = 1'b0;
    qif.enable    = 1'b1;
    qif.clear     = 1'b0;
    qif.error_clr = 1'b0;
    qif.quad_a    = 1'b1;
    qif.quad_b    = 1'b1;
    repeat (3) tick();
    check("rst_count", 32'(qif.count), 0);
    check("rst_dir",   32'(qif.dir),   1);
    check("rst_step",  32'(qif.step),  0);
    check("rst_error", 32'(qif.error), 0);

    reset = 1'b1;
    p = 0;
    e = 0;
    repeat (12) begin
      tick();
      if (qif.step === 1'b1)  p++;
      if (qif.error === 1'b1) e++;
    end
    check("init_steps",  32'(p), 0);
    check("init_errors", 32'(e), 0);
    check("init_count",  32'(qif.count), 0);
    check("init_dir",    32'(qif.dir),   1);

    // Re-reset with pins at 00 so the up sequence starts from 00
    reset      = 1'b0;
    qif.quad_a = 1'b0;
    qif.quad_b = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (10) tick();
    check("rerst_count", 32'(qif.count), 0);

    // ---------------- 2: 20 up transitions, wrap through 15->0 ----------------
    exp_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      logic [1:0] nxt;
      nxt = up_seq[i % 4];
      move(nxt[1], nxt[0], p, f);
      exp_cnt = (exp_cnt + 1) % 16;
      check($sformatf("up%0d_pulses", i), 32'(p), 1);
      check($sformatf("up%0d_latency", i), 32'(f), 6);
      check($sformatf("up%0d_dir", i), 32'(qif.dir), 1);
      check($sformatf("up%0d_count", i), 32'(qif.count), 32'(exp_cnt));
    end

    // ---------------- 3: clear, then one down transition ----------------
    qif.clear = 1'b1;
    tick();
    qif.clear = 1'b0;
    check("clear_count", 32'(qif.count), 0);
    move(1'b0, 1'b1, p, f);
    check("down_pulses",  32'(p), 1);
    check("down_latency", 32'(f), 6);
    check("down_dir",     32'(qif.dir),   0);
    check("down_count",   32'(qif.count), 15);

    // ---------------- 4: short glitches rejected ----------------
    qif.quad_a = 1'b1;
    repeat (2) tick();
    move(1'b0, 1'b1, p, f);
    check("glitch_a_pulses", 32'(p), 0);
    check("glitch_a_count",  32'(qif.count), 15);
    check("glitch_a_dir",    32'(qif.dir),   0);
    qif.quad_b = 1'b0;
    tick();
    move(1'b0, 1'b1, p, f);
    check("glitch_b_pulses", 32'(p), 0);
    check("glitch_b_count",  32'(qif.count), 15);
    check("glitch_b_error",  32'(qif.error), 0);

    // ---------------- 5: illegal transition, error clear, set-wins ----------------
    move(1'b1, 1'b0, p, f);
    check("illegal_pulses", 32'(p), 0);
    check("illegal_error",  32'(qif.error), 1);
    check("illegal_count",  32'(qif.count), 15);
    check("illegal_dir",    32'(qif.dir),   0);
    qif.error_clr = 1'b1;
    tick();
    qif.error_clr = 1'b0;
    check("errclr_error", 32'(qif.error), 0);

    qif.quad_a = 1'b0;
    qif.quad_b = 1'b1;
    p = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (qif.step === 1'b1) p++;
      if (i == 5) begin
        check("coinc_pre_error", 32'(qif.error), 0);
        qif.error_clr = 1'b1;
      end
      if (i == 6) begin
        check("coinc_set_wins", 32'(qif.error), 1);
        qif.error_clr = 1'b0;
      end
    end
    check("coinc_pulses", 32'(p), 0);
    check("coinc_error",  32'(qif.error), 1);
    check("coinc_count",  32'(qif.count), 15);

    // ---------------- 6: enable gating, clear on a step edge ----------------
    qif.enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] nxt;
      nxt = up_seq[(i + 3) % 4];
      move(nxt[1], nxt[0], p, f);
      check($sformatf("dis%0d_pulses", i), 32'(p), 0);
      check($sformatf("dis%0d_count", i), 32'(qif.count), 15);
      check($sformatf("dis%0d_dir", i), 32'(qif.dir), 0);
    end
    qif.enable = 1'b1;
    move(1'b0, 1'b0, p, f);
    check("reen_pulses",  32'(p), 1);
    check("reen_latency", 32'(f), 6);
    check("reen_dir",     32'(qif.dir),   1);
    check("reen_count",   32'(qif.count), 0);

    qif.quad_a = 1'b1;
    p = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (qif.step === 1'b1) p++;
      if (i == 5) qif.clear = 1'b1;
      if (i == 6) begin
        check("clrstep_step",  32'(qif.step),  1);
        check("clrstep_count", 32'(qif.count), 0);
        check("clrstep_dir",   32'(qif.dir),   1);
        qif.clear = 1'b0;
      end
    end
    check("clrstep_pulses", 32'(p), 1);

    // ---------------- mid-operation asynchronous reset ----------------
    move(1'b1, 1'b1, p, f);
    check("pre_rst_count", 32'(qif.count), 1);
    check("pre_rst_error", 32'(qif.error), 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_count", 32'(qif.count), 0);
    check("async_rst_error", 32'(qif.error), 0);
    check("async_rst_dir",   32'(qif.dir),   1);
    check("async_rst_step",  32'(qif.step),  0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
`default_nettype wire
